gsensor_x_filter: RTL

Conditioning stage between the SPI accelerometer reader and the LED tilt driver. It takes raw signed X-axis samples as they arrive and saturates them to 10 bits. It then produces a moving-average 10-bit tilt value (the LED driver's digital input) and a retriggerable, stretched "shake" level (the LED driver's interrupt input). Shake is raised when a new sample departs sharply from the current average.

---
 rtl/gsensor_x_filter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/gsensor_x_filter.sv
// gsensor_x_filter: X-axis conditioning between the SPI accelerometer reader
// and the LED tilt driver. Saturates raw samples to 10 bits, publishes a
// moving average over 2^LOG2_DEPTH samples, and raises a stretched shake
// level when a sample departs from the published average by more than THRESH.
//
// Ports:
//   iCLK        in   1   rising-edge clock
//   iRST        in   1   asynchronous active-high reset
//   iDATA       in  16   raw X sample, signed two's complement
//   iDATA_VALID in   1   one-cycle strobe, iDATA sampled when high
//   oDIG        out 10   signed moving average
//   oDIG_VALID  out  1   one-cycle strobe, oDIG updated this cycle
//   oSHAKE      out  1   shake level, HOLD_CYCLES long, retriggerable
module gsensor_x_filter #(
    parameter int unsigned LOG2_DEPTH  = 2,
    parameter int unsigned THRESH      = 64,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [15:0] iDATA,
    input  logic        iDATA_VALID,
    output logic [9:0]  oDIG,
    output logic        oDIG_VALID,
    output logic        oSHAKE
);

    localparam int unsigned DATA_W = 10;
    localparam int unsigned DEPTH  = 1 << LOG2_DEPTH;
    localparam int unsigned SUM_W  = DATA_W + LOG2_DEPTH;
    localparam int unsigned DIFF_W = DATA_W + 1;
    localparam int unsigned CNT_W  = 16;

    logic signed [15:0]       data_s;
    logic signed [DATA_W-1:0] sat_c;

    logic                     s1_valid;
    logic signed [DATA_W-1:0] s1_sample;

    logic signed [DATA_W-1:0] win_mem [DEPTH];
    logic [LOG2_DEPTH-1:0]    ptr;
    logic signed [SUM_W-1:0]  sum;
    logic                     s2_valid;

    logic signed [SUM_W-1:0]  new_sum_c;
    logic signed [DIFF_W-1:0] diff_c;
    logic signed [DIFF_W-1:0] abs_c;
    logic                     trigger_c;

    logic signed [DATA_W-1:0] dig_q;
    logic [CNT_W-1:0]         hold_cnt;

    assign data_s = $signed(iDATA);

    // Clamp the 16-bit raw sample into the signed 10-bit range.
    always_comb begin
        sat_c = data_s[DATA_W-1:0];
        if (data_s > 16'sd511) begin
            sat_c = 10'sh1FF;
        end else if (data_s < -16'sd512) begin
            sat_c = 10'sh200;
        end
    end

    // Stage 1: register saturated sample and its strobe.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
        end else begin
            s1_valid  <= iDATA_VALID;
            s1_sample <= sat_c;
        end
    end

    // Running-sum update and shake compare against the currently published average.
    always_comb begin
        new_sum_c = sum + SUM_W'(s1_sample) - SUM_W'(win_mem[ptr]);
        diff_c    = DIFF_W'(s1_sample) - DIFF_W'(dig_q);
        abs_c     = diff_c[DIFF_W-1] ? -diff_c : diff_c;
        trigger_c = s1_valid && ($unsigned(abs_c) > DIFF_W'(THRESH));
    end

    // Stage 2: window buffer, pointer and sum.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                win_mem[i] <= '0;
            end
            ptr      <= '0;
            sum      <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                win_mem[ptr] <= s1_sample;
                ptr          <= LOG2_DEPTH'(ptr + 1'b1);
                sum          <= new_sum_c;
            end
        end
    end

    // Hold counter: a trigger reloads and wins over the decrement.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            hold_cnt <= '0;
        end else if (trigger_c) begin
            hold_cnt <= CNT_W'(HOLD_CYCLES);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // Stage 3: publish average (floor via arithmetic slice), strobe and shake level.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            dig_q      <= '0;
            oDIG_VALID <= 1'b0;
            oSHAKE     <= 1'b0;
        end else begin
            oDIG_VALID <= s2_valid;
            oSHAKE     <= (hold_cnt != '0);
            if (s2_valid) begin
                dig_q <= sum[SUM_W-1:LOG2_DEPTH];
            end
        end
    end

    assign oDIG = dig_q;

endmodule
